// File: rtl/coin_key_filter.sv
// coin_key_filter
//   Conditions the two raw, bouncing, active-low coin-slot keys of the
//   vending machine. Each key is synchronised and debounced on its own;
//   every accepted press gives exactly one single-cycle pulse. The two
//   output pulses never overlap: when both keys are accepted on the same
//   edge the 1-unit pulse goes first and the 0.5-unit pulse follows on
//   the next cycle.
//
//   Ports
//     sys_clk        in   system clock, rising edge
//     sys_rst_n      in   asynchronous active-low reset
//     key_half_in    in   raw 0.5-unit coin key, active-low, asynchronous
//     key_one_in     in   raw 1-unit coin key, active-low, asynchronous
//     po_money_half  out  one-cycle pulse per accepted 0.5-unit coin
//     po_money_one   out  one-cycle pulse per accepted 1-unit coin
//
//   CNT_MAX: the debounce window is CNT_MAX+1 stable cycles (2..20'hFFFFF).

module coin_key_debounce #(
   parameter logic [19:0] CNT_MAX = 20'd999_999
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key,
   output logic press
);

   localparam logic [1:0] IDLE        = 2'd0;
   localparam logic [1:0] FILTER_DOWN = 2'd1;
   localparam logic [1:0] DOWN        = 2'd2;
   localparam logic [1:0] FILTER_UP   = 2'd3;

   logic        key_meta;
   logic        key_s;
   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [19:0] cnt;
   logic [19:0] cnt_nxt;

   // Two-flop synchroniser; resets to "released".
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         key_meta <= 1'b1;
         key_s    <= 1'b1;
      end else begin
         key_meta <= key;
         key_s    <= key_meta;
      end
   end

   // The counter is cleared on every state change and stops at CNT_MAX,
   // so it can never wrap.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      press     = 1'b0;
      case (state)
         IDLE: begin
            if (!key_s) begin
               state_nxt = FILTER_DOWN;
               cnt_nxt   = '0;
            end
         end
         FILTER_DOWN: begin
            if (key_s) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_MAX) begin
               state_nxt = DOWN;
               cnt_nxt   = '0;
               press     = 1'b1;
            end else begin
               cnt_nxt = cnt + 20'd1;
            end
         end
         DOWN: begin
            if (key_s) begin
               state_nxt = FILTER_UP;
               cnt_nxt   = '0;
            end
         end
         FILTER_UP: begin
            if (!key_s) begin
               state_nxt = DOWN;
               cnt_nxt   = '0;
            end else if (cnt == CNT_MAX) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 20'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

endmodule

module coin_key_filter #(
   parameter logic [19:0] CNT_MAX = 20'd999_999
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key_half_in,
   input  logic key_one_in,
   output logic po_money_half,
   output logic po_money_one
);

   logic half_evt;
   logic one_evt;
   logic half_pend;

   coin_key_debounce #(.CNT_MAX(CNT_MAX)) u_half (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key       (key_half_in),
      .press     (half_evt)
   );

   coin_key_debounce #(.CNT_MAX(CNT_MAX)) u_one (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key       (key_one_in),
      .press     (one_evt)
   );

   // The 1-unit event always wins the cycle; a colliding 0.5-unit event is
   // held for one cycle. A second half event cannot arrive while it waits
   // because the debounce window is at least three cycles long.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         po_money_one  <= 1'b0;
         po_money_half <= 1'b0;
         half_pend     <= 1'b0;
      end else begin
         po_money_one  <= one_evt;
         po_money_half <= (half_evt | half_pend) & ~one_evt;
         half_pend     <= half_evt & one_evt;
      end
   end

endmodule

// File: tb/tb_coin_key_filter.sv
module tb_coin_key_filter;

   localparam int CNT = 4;

   logic sys_clk;
   logic sys_rst_n;
   logic key_half_in;
   logic key_one_in;
   logic po_money_half;
   logic po_money_one;

   int total;
   int bad;

   coin_key_filter #(.CNT_MAX(20'd4)) dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .key_half_in   (key_half_in),
      .key_one_in    (key_one_in),
      .po_money_half (po_money_half),
      .po_money_one  (po_money_one)
   );

   initial begin
      sys_clk = 1'b0;
      forever #10 sys_clk = ~sys_clk;
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------
   // Behavioural model. A key press is accepted once the synchronised
   // key (the raw sample two edges ago) has disagreed with the settled
   // level for CNT+2 consecutive edges; any agreeing sample restarts the
   // run. Press acceptances become pulses; a half pulse that collides
   // with a one pulse is owed and paid out on the first free cycle.
   // ---------------------------------------------------------------
   int edge_no;
   bit raw_d1 [2];
   bit raw_d2 [2];
   bit lvl    [2];
   int run    [2];
   int owed;
   bit exp_half;
   bit exp_one;

   initial begin
      edge_no  = 0;
      owed     = 0;
      exp_half = 0;
      exp_one  = 0;
      for (int k = 0; k < 2; k++) begin
         raw_d1[k] = 1; raw_d2[k] = 1; lvl[k] = 1; run[k] = 0;
      end
   end

   always @(posedge sys_clk) begin
      bit evt [2];
      bit raw [2];
      bit ks;
      edge_no++;
      raw[0] = key_half_in;
      raw[1] = key_one_in;
      if (!sys_rst_n) begin
         for (int k = 0; k < 2; k++) begin
            raw_d1[k] = 1; raw_d2[k] = 1; lvl[k] = 1; run[k] = 0;
         end
         owed = 0; exp_half = 0; exp_one = 0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            evt[k] = 0;
            ks = raw_d2[k];
            if (ks != lvl[k]) begin
               run[k]++;
               if (run[k] == CNT + 2) begin
                  lvl[k] = ks;
                  run[k] = 0;
                  evt[k] = (ks == 1'b0);
               end
            end else begin
               run[k] = 0;
            end
            raw_d2[k] = raw_d1[k];
            raw_d1[k] = raw[k];
         end
         exp_one = evt[1];
         if (evt[1]) begin
            exp_half = 0;
            if (evt[0]) owed++;
         end else if (evt[0]) begin
            exp_half = 1;
         end else if (owed > 0) begin
            exp_half = 1;
            owed--;
         end else begin
            exp_half = 0;
         end
      end
   end

   // Compare process plus pulse bookkeeping, half a cycle after each edge.
   int n_one, n_half, last_one, last_half;
   initial begin
      n_one = 0; n_half = 0; last_one = -1; last_half = -1;
   end

   always @(posedge sys_clk) begin
      #5;
      check("po_money_one", int'(po_money_one), int'(exp_one));
      check("po_money_half", int'(po_money_half), int'(exp_half));
      check("mutex", int'(po_money_one & po_money_half), 0);
      if (po_money_one === 1'b1) begin n_one++; last_one = edge_no; end
      if (po_money_half === 1'b1) begin n_half++; last_half = edge_no; end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   int s;
   int s2;

   initial begin
      total = 0;
      bad   = 0;
      sys_rst_n   = 1'b0;
      key_half_in = 1'b1;
      key_one_in  = 1'b1;
      #15;
      check("reset_one", int'(po_money_one), 0);
      check("reset_half", int'(po_money_half), 0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      cycles(10);
      check("idle_no_pulse", n_one + n_half, 0);

      // clean press, then a second press after release
      key_one_in = 1'b0; s = edge_no + 1;
      cycles(40);
      check("press1_count", n_one, 1);
      check("press1_edge", last_one - s + 1, 8);
      check("press1_half", n_half, 0);
      key_one_in = 1'b1;
      cycles(20);
      key_one_in = 1'b0; s = edge_no + 1;
      cycles(40);
      check("press2_count", n_one, 2);
      check("press2_edge", last_one - s + 1, 8);
      key_one_in = 1'b1;
      cycles(20);

      // bounce, then stable low
      for (int i = 0; i < 6; i++) begin
         key_half_in = i[0];
         cycles(2);
      end
      key_half_in = 1'b0; s = edge_no + 1;
      cycles(40);
      check("bounce_count", n_half, 1);
      check("bounce_edge", last_half - s + 1, 8);
      key_half_in = 1'b1;
      cycles(20);

      // short glitch
      key_half_in = 1'b0;
      cycles(3);
      key_half_in = 1'b1;
      cycles(20);
      check("glitch_count", n_half, 1);

      // simultaneous keys
      key_half_in = 1'b0; key_one_in = 1'b0; s = edge_no + 1;
      cycles(40);
      check("simul_one_count", n_one, 3);
      check("simul_one_edge", last_one - s + 1, 8);
      check("simul_half_count", n_half, 2);
      check("simul_half_edge", last_half - s + 1, 9);
      key_half_in = 1'b1; key_one_in = 1'b1;
      cycles(20);

      // reset in the middle of the filter (cnt=2 after edge 5)
      key_one_in = 1'b0; s = edge_no + 1;
      cycles(5);
      sys_rst_n = 1'b0;
      cycles(3);
      check("rst_mid_no_pulse", n_one, 3);
      sys_rst_n = 1'b1; s2 = edge_no + 1;
      cycles(40);
      check("rst_mid_count", n_one, 4);
      check("rst_mid_edge", last_one - s2 + 1, 8);
      check("rst_mid_half", n_half, 2);
      key_one_in = 1'b1;
      cycles(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
